// File: rtl/framebuffer_arbiter_pkg.sv
// Shared arbiter state encodings and default widths for the framebuffer path
// (pixel memory, VGA read pointer and the memory arbiter).
package framebuffer_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_READ  = 2'd1,
        ARB_WRITE = 2'd2
    } arb_state_t;

    localparam int DEFAULT_ADDRESS_WIDTH    = 22;
    localparam int DEFAULT_DATA_WIDTH       = 12;
    localparam int DEFAULT_WRITE_FIFO_DEPTH = 8;
    localparam int DEFAULT_MAX_WRITE_WAIT   = 4;

    // Bits needed to hold a counter that saturates at max_value.
    function automatic int count_width(input int max_value);
        return (max_value < 1) ? 1 : $clog2(max_value + 1);
    endfunction

endpackage

// File: rtl/framebuffer_arbiter_sync_fifo.sv
// Write buffer for the framebuffer arbiter: RAM array with a registered head
// stage, so a pushed entry becomes poppable one edge after it is written.
module sync_fifo
    import framebuffer_arbiter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_ADDRESS_WIDTH + DEFAULT_DATA_WIDTH,
    parameter int DEPTH = DEFAULT_WRITE_FIFO_DEPTH
) (
    input  logic                     system_clock,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_WIDTH   = $clog2(DEPTH);
    localparam int LEVEL_WIDTH = PTR_WIDTH + 1;
    localparam logic [LEVEL_WIDTH-1:0] DEPTH_COUNT = LEVEL_WIDTH'(DEPTH);

    logic [WIDTH-1:0]       storage [DEPTH];
    logic [PTR_WIDTH:0]     write_ptr_reg;
    logic [PTR_WIDTH:0]     read_ptr_reg;
    logic [LEVEL_WIDTH-1:0] level_reg;
    logic                   head_valid_reg;
    logic [WIDTH-1:0]       head_data_reg;
    logic                   do_push;
    logic                   do_pop;
    logic                   array_has_data;
    logic                   load_head;

    assign do_push        = push && (level_reg != DEPTH_COUNT);
    assign do_pop         = pop && head_valid_reg;
    assign array_has_data = (write_ptr_reg != read_ptr_reg);
    // Refill the head stage whenever it is empty or being consumed this edge.
    assign load_head      = array_has_data && (!head_valid_reg || do_pop);

    always_ff @(posedge system_clock) begin
        if (do_push) begin
            storage[write_ptr_reg[PTR_WIDTH-1:0]] <= push_data;
        end
        if (load_head) begin
            head_data_reg <= storage[read_ptr_reg[PTR_WIDTH-1:0]];
        end
    end

    always_ff @(posedge system_clock or negedge reset_n) begin
        if (!reset_n) begin
            write_ptr_reg  <= '0;
            read_ptr_reg   <= '0;
            level_reg      <= '0;
            head_valid_reg <= 1'b0;
        end else begin
            if (do_push) begin
                write_ptr_reg <= write_ptr_reg + 1'b1;
            end
            if (load_head) begin
                read_ptr_reg   <= read_ptr_reg + 1'b1;
                head_valid_reg <= 1'b1;
            end else if (do_pop) begin
                head_valid_reg <= 1'b0;
            end
            case ({do_push, do_pop})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase
        end
    end

    // level counts every stored entry; empty only reflects the head stage.
    assign head_data = head_data_reg;
    assign level     = level_reg;
    assign full      = (level_reg == DEPTH_COUNT);
    assign empty     = !head_valid_reg;

endmodule

// File: rtl/framebuffer_arbiter.sv
// Single-port framebuffer arbiter: VGA reads have priority, buffered MCU pixel
// writes are guaranteed a slot after MAX_WRITE_WAIT consecutive read grants.
module framebuffer_arbiter
    import framebuffer_arbiter_pkg::*;
#(
    parameter int ADDRESS_WIDTH    = DEFAULT_ADDRESS_WIDTH,
    parameter int DATA_WIDTH       = DEFAULT_DATA_WIDTH,
    parameter int WRITE_FIFO_DEPTH = DEFAULT_WRITE_FIFO_DEPTH,
    parameter int MAX_WRITE_WAIT   = DEFAULT_MAX_WRITE_WAIT
) (
    input  logic                                system_clock,
    input  logic                                reset_n,
    input  logic                                write_request,
    input  logic [ADDRESS_WIDTH-1:0]            write_address,
    input  logic [DATA_WIDTH-1:0]               write_data,
    output logic                                write_ready,
    input  logic                                read_request,
    input  logic [ADDRESS_WIDTH-1:0]            read_address,
    output logic                                read_ready,
    output logic                                read_valid,
    output logic [DATA_WIDTH-1:0]               read_data,
    output logic                                memory_enable,
    output logic                                memory_write_enable,
    output logic [ADDRESS_WIDTH-1:0]            memory_address,
    output logic [DATA_WIDTH-1:0]               memory_write_data,
    input  logic [DATA_WIDTH-1:0]               memory_read_data,
    output logic                                write_overflow,
    input  logic                                write_overflow_clear,
    output logic [$clog2(WRITE_FIFO_DEPTH):0]   fifo_level
);

    localparam int ENTRY_WIDTH  = ADDRESS_WIDTH + DATA_WIDTH;
    localparam int STARVE_WIDTH = count_width(MAX_WRITE_WAIT);
    localparam logic [STARVE_WIDTH-1:0] STARVE_LIMIT = STARVE_WIDTH'(MAX_WRITE_WAIT);

    arb_state_t                 state_reg;
    arb_state_t                 state_next;
    logic [STARVE_WIDTH-1:0]    starve_count_reg;
    logic [STARVE_WIDTH-1:0]    starve_count_next;
    logic                       memory_enable_reg;
    logic                       memory_enable_next;
    logic                       memory_write_enable_reg;
    logic                       memory_write_enable_next;
    logic [ADDRESS_WIDTH-1:0]   memory_address_reg;
    logic [ADDRESS_WIDTH-1:0]   memory_address_next;
    logic [DATA_WIDTH-1:0]      memory_write_data_reg;
    logic [DATA_WIDTH-1:0]      memory_write_data_next;
    logic                       read_pending_reg;
    logic                       read_valid_reg;
    logic [DATA_WIDTH-1:0]      read_data_reg;
    logic                       write_overflow_reg;

    logic [ENTRY_WIDTH-1:0]     fifo_head;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic                       fifo_push;
    logic                       fifo_pop;
    logic                       forced_write;
    logic                       read_accept;

    sync_fifo #(
        .WIDTH (ENTRY_WIDTH),
        .DEPTH (WRITE_FIFO_DEPTH)
    ) write_fifo (
        .system_clock (system_clock),
        .reset_n      (reset_n),
        .push         (fifo_push),
        .push_data    ({write_address, write_data}),
        .pop          (fifo_pop),
        .head_data    (fifo_head),
        .level        (fifo_level),
        .full         (fifo_full),
        .empty        (fifo_empty)
    );

    assign write_ready  = !fifo_full;
    assign fifo_push    = write_request && write_ready;
    assign forced_write = (starve_count_reg == STARVE_LIMIT) && !fifo_empty;
    assign read_ready   = !forced_write;
    assign read_accept  = read_request && read_ready;

    always_comb begin
        state_next             = ARB_IDLE;
        starve_count_next      = '0;
        fifo_pop               = 1'b0;
        memory_address_next    = memory_address_reg;
        memory_write_data_next = memory_write_data_reg;

        if (forced_write) begin
            state_next             = ARB_WRITE;
            fifo_pop               = 1'b1;
            memory_address_next    = fifo_head[ENTRY_WIDTH-1:DATA_WIDTH];
            memory_write_data_next = fifo_head[DATA_WIDTH-1:0];
        end else if (read_accept) begin
            state_next          = ARB_READ;
            memory_address_next = read_address;
            // Only reads that hold back a queued write count toward starvation.
            if (!fifo_empty) begin
                starve_count_next = (starve_count_reg == STARVE_LIMIT) ?
                                    starve_count_reg : starve_count_reg + 1'b1;
            end
        end else if (!fifo_empty) begin
            state_next             = ARB_WRITE;
            fifo_pop               = 1'b1;
            memory_address_next    = fifo_head[ENTRY_WIDTH-1:DATA_WIDTH];
            memory_write_data_next = fifo_head[DATA_WIDTH-1:0];
        end

        memory_enable_next       = (state_next != ARB_IDLE);
        memory_write_enable_next = (state_next == ARB_WRITE);
    end

    always_ff @(posedge system_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg               <= ARB_IDLE;
            starve_count_reg        <= '0;
            memory_enable_reg       <= 1'b0;
            memory_write_enable_reg <= 1'b0;
            memory_address_reg      <= '0;
            memory_write_data_reg   <= '0;
        end else begin
            state_reg               <= state_next;
            starve_count_reg        <= starve_count_next;
            memory_enable_reg       <= memory_enable_next;
            memory_write_enable_reg <= memory_write_enable_next;
            memory_address_reg      <= memory_address_next;
            memory_write_data_reg   <= memory_write_data_next;
        end
    end

    // Read return: memory samples the address one edge after issue and its
    // output is captured on the following edge.
    always_ff @(posedge system_clock or negedge reset_n) begin
        if (!reset_n) begin
            read_pending_reg <= 1'b0;
            read_valid_reg   <= 1'b0;
            read_data_reg    <= '0;
        end else begin
            read_pending_reg <= (state_reg == ARB_READ);
            read_valid_reg   <= read_pending_reg;
            if (read_pending_reg) begin
                read_data_reg <= memory_read_data;
            end
        end
    end

    // A fresh overflow wins over a simultaneous clear.
    always_ff @(posedge system_clock or negedge reset_n) begin
        if (!reset_n) begin
            write_overflow_reg <= 1'b0;
        end else if (write_request && !write_ready) begin
            write_overflow_reg <= 1'b1;
        end else if (write_overflow_clear) begin
            write_overflow_reg <= 1'b0;
        end
    end

    assign memory_enable       = memory_enable_reg;
    assign memory_write_enable = memory_write_enable_reg;
    assign memory_address      = memory_address_reg;
    assign memory_write_data   = memory_write_data_reg;
    assign read_valid          = read_valid_reg;
    assign read_data           = read_data_reg;
    assign write_overflow      = write_overflow_reg;

endmodule

// File: tb/tb_framebuffer_arbiter.sv
// Directed bench for framebuffer_arbiter with a behavioural pixel memory that
// logs every memory access.
module tb_framebuffer_arbiter;

    logic        system_clock;
    logic        reset_n;
    logic        write_request;
    logic [21:0] write_address;
    logic [11:0] write_data;
    logic        write_ready;
    logic        read_request;
    logic [21:0] read_address;
    logic        read_ready;
    logic        read_valid;
    logic [11:0] read_data;
    logic        memory_enable;
    logic        memory_write_enable;
    logic [21:0] memory_address;
    logic [11:0] memory_write_data;
    logic [11:0] memory_read_data;
    logic        write_overflow;
    logic        write_overflow_clear;
    logic [3:0]  fifo_level;

    int tests_run = 0;
    int tests_failed = 0;

    framebuffer_arbiter #(
        .ADDRESS_WIDTH    (22),
        .DATA_WIDTH       (12),
        .WRITE_FIFO_DEPTH (8),
        .MAX_WRITE_WAIT   (4)
    ) dut (
        .system_clock         (system_clock),
        .reset_n              (reset_n),
        .write_request        (write_request),
        .write_address        (write_address),
        .write_data           (write_data),
        .write_ready          (write_ready),
        .read_request         (read_request),
        .read_address         (read_address),
        .read_ready           (read_ready),
        .read_valid           (read_valid),
        .read_data            (read_data),
        .memory_enable        (memory_enable),
        .memory_write_enable  (memory_write_enable),
        .memory_address       (memory_address),
        .memory_write_data    (memory_write_data),
        .memory_read_data     (memory_read_data),
        .write_overflow       (write_overflow),
        .write_overflow_clear (write_overflow_clear),
        .fifo_level           (fifo_level)
    );

    initial system_clock = 1'b0;
    always #5 system_clock = ~system_clock;

    // Pixel memory model: registered read, write history for ordering checks.
    logic [11:0] mem_model [256];
    logic [11:0] mem_rdata;
    logic        preload_en;
    logic [7:0]  preload_addr;
    logic [11:0] preload_data;
    int          wr_count = 0;
    logic [21:0] wr_addr_hist [64];
    logic [11:0] wr_data_hist [64];

    always @(posedge system_clock) begin
        if (preload_en) begin
            mem_model[preload_addr] <= preload_data;
        end
        if (memory_enable) begin
            if (memory_write_enable) begin
                mem_model[memory_address[7:0]] <= memory_write_data;
                wr_addr_hist[wr_count % 64] <= memory_address;
                wr_data_hist[wr_count % 64] <= memory_write_data;
                wr_count <= wr_count + 1;
                $display("[TB] mem write addr=0x%0h data=0x%0h", memory_address, memory_write_data);
            end else begin
                mem_rdata <= mem_model[memory_address[7:0]];
                $display("[TB] mem read  addr=0x%0h", memory_address);
            end
        end
    end
    assign memory_read_data = mem_rdata;

    task automatic step();
        @(posedge system_clock);
        #1;
    endtask

    task automatic preload(input logic [7:0] addr, input logic [11:0] data);
        preload_en   = 1'b1;
        preload_addr = addr;
        preload_data = data;
        step();
        preload_en = 1'b0;
    endtask

    task automatic test_reset();
        tests_run++; if (memory_enable !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_en: got %b want 0", memory_enable); end
        tests_run++; if (memory_write_enable !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_we: got %b want 0", memory_write_enable); end
        tests_run++; if (memory_address !== 22'h0) begin tests_failed++; $display("FAIL reset_mem_addr: got %h want 0", memory_address); end
        tests_run++; if (memory_write_data !== 12'h0) begin tests_failed++; $display("FAIL reset_mem_wdata: got %h want 0", memory_write_data); end
        tests_run++; if (read_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_read_valid: got %b want 0", read_valid); end
        tests_run++; if (read_data !== 12'h0) begin tests_failed++; $display("FAIL reset_read_data: got %h want 0", read_data); end
        tests_run++; if (write_overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow: got %b want 0", write_overflow); end
        tests_run++; if (write_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_write_ready: got %b want 1", write_ready); end
        tests_run++; if (read_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_read_ready: got %b want 1", read_ready); end
        tests_run++; if (fifo_level !== 4'd0) begin tests_failed++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
    endtask

    task automatic test_single_read();
        int base;
        base = wr_count;
        read_request = 1'b1;
        read_address = 22'h10;
        tests_run++; if (read_ready !== 1'b1) begin tests_failed++; $display("FAIL rd_ready_idle: got %b want 1", read_ready); end
        step();
        read_request = 1'b0;
        tests_run++; if (memory_enable !== 1'b1 || memory_write_enable !== 1'b0 || memory_address !== 22'h10)
            begin tests_failed++; $display("FAIL rd_issue: got en=%b we=%b addr=%h want en=1 we=0 addr=10", memory_enable, memory_write_enable, memory_address); end
        tests_run++; if (read_valid !== 1'b0) begin tests_failed++; $display("FAIL rd_valid_k0: got %b want 0", read_valid); end
        step();
        tests_run++; if (read_valid !== 1'b0) begin tests_failed++; $display("FAIL rd_valid_k1: got %b want 0", read_valid); end
        step();
        tests_run++; if (read_valid !== 1'b1 || read_data !== 12'hABC)
            begin tests_failed++; $display("FAIL rd_return: got valid=%b data=%h want valid=1 data=abc", read_valid, read_data); end
        $display("[TB] read addr=0x10 data=0x%0h", read_data);
        step();
        tests_run++; if (read_valid !== 1'b0) begin tests_failed++; $display("FAIL rd_valid_pulse: got %b want 0", read_valid); end
        tests_run++; if (wr_count !== base) begin tests_failed++; $display("FAIL rd_no_write: got %0d writes want 0", wr_count - base); end
    endtask

    task automatic test_writes();
        logic [3:0]  exp_level [6] = '{4'd1, 4'd2, 4'd2, 4'd1, 4'd0, 4'd0};
        logic        exp_en    [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [21:0] exp_addr  [6] = '{22'h0, 22'h0, 22'h1, 22'h2, 22'h3, 22'h0};
        logic [11:0] exp_data  [6] = '{12'h0, 12'h0, 12'h111, 12'h222, 12'h333, 12'h0};
        for (int c = 0; c < 6; c++) begin
            write_request = (c < 3);
            write_address = 22'(c + 1);
            write_data    = 12'(12'h111 * (c + 1));
            step();
            write_request = 1'b0;
            tests_run++; if (fifo_level !== exp_level[c]) begin tests_failed++; $display("FAIL wr_level[%0d]: got %0d want %0d", c, fifo_level, exp_level[c]); end
            tests_run++; if (memory_enable !== exp_en[c]) begin tests_failed++; $display("FAIL wr_en[%0d]: got %b want %b", c, memory_enable, exp_en[c]); end
            if (exp_en[c]) begin
                tests_run++; if (memory_write_enable !== 1'b1 || memory_address !== exp_addr[c] || memory_write_data !== exp_data[c])
                    begin tests_failed++; $display("FAIL wr_issue[%0d]: got we=%b addr=%h data=%h want we=1 addr=%h data=%h", c, memory_write_enable, memory_address, memory_write_data, exp_addr[c], exp_data[c]); end
            end
        end
    endtask

    task automatic test_starvation();
        logic        exp_ready [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [11:0] got [$];
        int accepted;
        int base;
        accepted = 0;
        base = wr_count;
        read_request = 1'b1;
        for (int s = 0; s < 10; s++) begin
            read_address  = 22'(22'h40 + accepted);
            write_request = (s == 0);
            write_address = 22'h30;
            write_data    = 12'h777;
            if (read_ready) accepted++;
            step();
            write_request = 1'b0;
            if (read_valid) got.push_back(read_data);
            tests_run++; if (read_ready !== exp_ready[s]) begin tests_failed++; $display("FAIL starve_ready[%0d]: got %b want %b", s, read_ready, exp_ready[s]); end
            if (s == 6) begin
                tests_run++; if (memory_write_enable !== 1'b1 || memory_address !== 22'h30 || memory_write_data !== 12'h777)
                    begin tests_failed++; $display("FAIL starve_forced: got we=%b addr=%h data=%h want we=1 addr=30 data=777", memory_write_enable, memory_address, memory_write_data); end
            end
        end
        read_request = 1'b0;
        for (int s = 0; s < 3; s++) begin
            step();
            if (read_valid) got.push_back(read_data);
        end
        tests_run++; if (accepted !== 9) begin tests_failed++; $display("FAIL starve_accepted: got %0d want 9", accepted); end
        tests_run++; if (got.size() !== 9) begin tests_failed++; $display("FAIL starve_results: got %0d want 9", got.size()); end
        for (int i = 0; i < got.size() && i < 9; i++) begin
            $display("[TB] read addr=0x%0h data=0x%0h", 22'h40 + i, got[i]);
            tests_run++; if (got[i] !== 12'(12'h100 + i)) begin tests_failed++; $display("FAIL starve_data[%0d]: got %h want %h", i, got[i], 12'h100 + i); end
        end
        tests_run++; if (wr_count - base !== 1) begin tests_failed++; $display("FAIL starve_writes: got %0d want 1", wr_count - base); end
    endtask

    task automatic test_overflow();
        logic [3:0] exp_level [10] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd6, 4'd7, 4'd8, 4'd8};
        int base;
        base = wr_count;
        read_request = 1'b1;
        read_address = 22'h0;
        for (int p = 0; p < 10; p++) begin
            write_request = 1'b1;
            write_address = 22'(22'h50 + p);
            write_data    = 12'(12'h200 + p);
            step();
            tests_run++; if (fifo_level !== exp_level[p]) begin tests_failed++; $display("FAIL ovf_level[%0d]: got %0d want %0d", p, fifo_level, exp_level[p]); end
            if (p == 8) begin
                tests_run++; if (write_ready !== 1'b0) begin tests_failed++; $display("FAIL ovf_full_ready: got %b want 0", write_ready); end
                tests_run++; if (write_overflow !== 1'b0) begin tests_failed++; $display("FAIL ovf_early: got %b want 0", write_overflow); end
            end
        end
        tests_run++; if (write_overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_set: got %b want 1", write_overflow); end
        write_address        = 22'h5A;
        write_data           = 12'h20A;
        write_overflow_clear = 1'b1;
        step();
        write_overflow_clear = 1'b0;
        write_request        = 1'b0;
        read_request         = 1'b0;
        tests_run++; if (write_overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_set_wins: got %b want 1", write_overflow); end
        for (int d = 0; d < 12; d++) step();
        tests_run++; if (write_overflow !== 1'b1 || fifo_level !== 4'd0)
            begin tests_failed++; $display("FAIL ovf_sticky: got ovf=%b level=%0d want ovf=1 level=0", write_overflow, fifo_level); end
        write_overflow_clear = 1'b1;
        step();
        write_overflow_clear = 1'b0;
        tests_run++; if (write_overflow !== 1'b0) begin tests_failed++; $display("FAIL ovf_clear: got %b want 0", write_overflow); end
        tests_run++; if (wr_count - base !== 9) begin tests_failed++; $display("FAIL ovf_write_count: got %0d want 9", wr_count - base); end
        for (int i = 0; i < 9; i++) begin
            tests_run++; if (wr_addr_hist[(base + i) % 64] !== 22'(22'h50 + i) || wr_data_hist[(base + i) % 64] !== 12'(12'h200 + i))
                begin tests_failed++; $display("FAIL ovf_order[%0d]: got addr=%h data=%h want addr=%h data=%h", i, wr_addr_hist[(base + i) % 64], wr_data_hist[(base + i) % 64], 22'h50 + i, 12'h200 + i); end
        end
    endtask

    task automatic test_reset_mid_op();
        int base;
        base = wr_count;
        read_request = 1'b1;
        read_address = 22'h40;
        for (int p = 0; p < 5; p++) begin
            write_request = 1'b1;
            write_address = 22'(22'h60 + p);
            write_data    = 12'(12'h300 + p);
            step();
        end
        write_request = 1'b0;
        read_request  = 1'b0;
        tests_run++; if (fifo_level !== 4'd5 || memory_enable !== 1'b1)
            begin tests_failed++; $display("FAIL rst_setup: got level=%0d en=%b want level=5 en=1", fifo_level, memory_enable); end
        reset_n = 1'b0;
        #1;
        tests_run++; if (memory_enable !== 1'b0 || memory_write_enable !== 1'b0 || memory_address !== 22'h0 || memory_write_data !== 12'h0)
            begin tests_failed++; $display("FAIL rst_mem_outputs: got en=%b we=%b addr=%h data=%h want all 0", memory_enable, memory_write_enable, memory_address, memory_write_data); end
        tests_run++; if (read_valid !== 1'b0 || read_data !== 12'h0)
            begin tests_failed++; $display("FAIL rst_read_outputs: got valid=%b data=%h want 0", read_valid, read_data); end
        tests_run++; if (fifo_level !== 4'd0 || write_ready !== 1'b1 || read_ready !== 1'b1 || write_overflow !== 1'b0)
            begin tests_failed++; $display("FAIL rst_status: got level=%0d wready=%b rready=%b ovf=%b want 0,1,1,0", fifo_level, write_ready, read_ready, write_overflow); end
        step();
        step();
        reset_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            tests_run++; if (read_valid !== 1'b0 || memory_enable !== 1'b0)
                begin tests_failed++; $display("FAIL rst_quiet[%0d]: got valid=%b en=%b want 0", c, read_valid, memory_enable); end
        end
        tests_run++; if (wr_count !== base) begin tests_failed++; $display("FAIL rst_no_write: got %0d writes want 0", wr_count - base); end
    endtask

    task automatic test_no_snoop();
        int base;
        base = wr_count;
        write_request = 1'b1;
        write_address = 22'h20;
        write_data    = 12'h555;
        read_request  = 1'b1;
        read_address  = 22'h20;
        step();
        write_request = 1'b0;
        read_request  = 1'b0;
        step();
        step();
        tests_run++; if (read_valid !== 1'b1 || read_data !== 12'h0AA)
            begin tests_failed++; $display("FAIL snoop_old: got valid=%b data=%h want valid=1 data=0aa", read_valid, read_data); end
        $display("[TB] read addr=0x20 data=0x%0h (write queued)", read_data);
        step();
        step();
        read_request = 1'b1;
        step();
        read_request = 1'b0;
        step();
        step();
        tests_run++; if (read_valid !== 1'b1 || read_data !== 12'h555)
            begin tests_failed++; $display("FAIL snoop_new: got valid=%b data=%h want valid=1 data=555", read_valid, read_data); end
        $display("[TB] read addr=0x20 data=0x%0h (write drained)", read_data);
        tests_run++; if (wr_count - base !== 1) begin tests_failed++; $display("FAIL snoop_writes: got %0d want 1", wr_count - base); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n              = 1'b0;
        write_request        = 1'b0;
        write_address        = '0;
        write_data           = '0;
        read_request         = 1'b0;
        read_address         = '0;
        write_overflow_clear = 1'b0;
        preload_en           = 1'b0;
        preload_addr         = '0;
        preload_data         = '0;
        preload(8'h10, 12'hABC);
        preload(8'h20, 12'h0AA);
        for (int i = 0; i < 9; i++) preload(8'(8'h40 + i), 12'(12'h100 + i));
        test_reset();
        reset_n = 1'b1;
        step();
        test_single_read();
        test_writes();
        test_starvation();
        test_overflow();
        test_reset_mid_op();
        test_no_snoop();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/framebuffer_arbiter.md
# framebuffer_arbiter

Single-port framebuffer memory controller that shares pixel memory between the MCU pixel-write path (message broker side) and the VGA read path, all in the `system_clock` domain. Writes are absorbed into a small internal FIFO. Reads have priority, but a starvation counter guarantees writes forward progress. The block sits between the message broker/VGA prefetch logic and the pixel memory array, driving all memory control signals from registers.

## Interface

Parameters:
- `ADDRESS_WIDTH`, default 22: framebuffer address width.
- `DATA_WIDTH`, default 12: pixel width (RGB444).
- `WRITE_FIFO_DEPTH`, default 8: write buffer entries; must be a power of two, at least 2.
- `MAX_WRITE_WAIT`, default 4: consecutive read grants allowed while the FIFO is non-empty before one write slot is forced.

Ports:
- `system_clock` in 1: single clock for the block.
- `reset_n` in 1: asynchronous, active-low reset.
- `write_request` in 1: pixel write offered.
- `write_address` in ADDRESS_WIDTH: write target.
- `write_data` in DATA_WIDTH: pixel value.
- `write_ready` out 1: FIFO not full.
- `read_request` in 1: pixel read offered.
- `read_address` in ADDRESS_WIDTH: read target.
- `read_ready` out 1: read will be accepted this cycle.
- `read_valid` out 1: `read_data` valid, single-cycle pulse.
- `read_data` out DATA_WIDTH: returned pixel.
- `memory_enable` out 1: memory access this cycle.
- `memory_write_enable` out 1: access is a write.
- `memory_address` out ADDRESS_WIDTH: memory address.
- `memory_write_data` out DATA_WIDTH: write data.
- `memory_read_data` in DATA_WIDTH: memory output, valid one cycle after a read access.
- `write_overflow` out 1: sticky, set when a write is offered while full.
- `write_overflow_clear` in 1: clears `write_overflow`.
- `fifo_level` out $clog2(WRITE_FIFO_DEPTH)+1: current FIFO occupancy.

## Operation

- A write is accepted on an edge where `write_request && write_ready`. Address and data are pushed together.
- A write offered while `write_ready`=0 is dropped and sets `write_overflow`.
- If `write_overflow_clear` and a new overflow occur in the same cycle, the flag stays set.
- A read is accepted on an edge where `read_request && read_ready`.
- `read_ready` = !(`starve_count` == MAX_WRITE_WAIT && FIFO non-empty).
- Arbiter state registers what the memory port does in the next cycle:
  - IDLE: no access.
  - READ: accepted read issued.
  - WRITE: FIFO head issued and popped.
- State selection on each edge, in priority order:
  1. Forced write (starvation limit reached, FIFO non-empty) → WRITE, `starve_count` ← 0.
  2. Accepted read → READ. `starve_count` increments (saturating) if the FIFO is non-empty, else ← 0.
  3. FIFO non-empty → WRITE, `starve_count` ← 0.
  4. Otherwise → IDLE.
- Pop happens on the edge entering WRITE. A push and a pop on the same edge leave the level unchanged.
- `write_ready` = level < WRITE_FIFO_DEPTH, computed from the registered level. A pop does not make room for a push on the same edge.
- The FIFO pointers wrap modulo WRITE_FIFO_DEPTH, with one extra bit used to distinguish full from empty.
- Write ordering is preserved: FIFO order equals memory write order.
- Reads do not snoop the FIFO. A read of an address with a pending write returns the old memory contents.

## Timing

- Read accepted at edge k:
  - `memory_enable`=1, `memory_write_enable`=0, `memory_address`=`read_address` during cycle k..k+1.
  - `memory_read_data` captured at edge k+2.
  - `read_valid`=1 with `read_data` during cycle k+2..k+3.
  - Fixed latency of 2 cycles. Back-to-back reads give one result per cycle.
- Write popped at edge k: memory write performed during cycle k..k+1. Best-case push-to-memory latency is 2 cycles.
- Reset values (`reset_n`=0, asynchronous):
  - State IDLE; FIFO empty.
  - `starve_count`=0, `fifo_level`=0.
  - `memory_enable`=0, `memory_write_enable`=0, `memory_address`=0, `memory_write_data`=0.
  - `read_valid`=0, `read_data`=0.
  - `write_overflow`=0, `write_ready`=1, `read_ready`=1.
- Reset asserted mid-operation discards FIFO contents and any in-flight read. `read_valid` is not produced for it after reset release.

## Structure

- Shared include `framebuffer_defines.v` holds:
  - arbiter state encodings (IDLE=0, READ=1, WRITE=2);
  - default widths, shared with `pixel_memory` and the `vga` read pointer.
- One sub-module, `sync_fifo`, parameterized by width (ADDRESS_WIDTH+DATA_WIDTH) and depth. It provides push, pop, level, full and empty outputs and an asynchronous active-low reset.
- Arbiter FSM, starvation counter and read-return pipeline live in `framebuffer_arbiter`.

## Test plan

- Reset, then a single read of address 0x10 with memory preloaded to 0xABC → `read_valid` exactly 2 cycles after acceptance, `read_data`=0xABC, memory write enable never asserted.
- Push 3 writes (0x1→0x111, 0x2→0x222, 0x3→0x333) with no reads → three consecutive WRITE cycles in order; `fifo_level` goes 1,2,2,1,0 as pushes and pops overlap.
- Continuous `read_request` with 1 pending write, MAX_WRITE_WAIT=4 → 4 reads, then `read_ready`=0 for one cycle and the write issued, then reads resume. No read is lost or duplicated.
- Fill the FIFO to 8 with reads saturating the port, then offer a 9th write → `write_ready`=0, `write_overflow`=1 and stays set. `write_overflow_clear` pulse → 0. Memory never sees the dropped write.
- Assert `reset_n`=0 with 5 writes queued and a read in flight → all outputs take reset values immediately. After release, no `read_valid` and no memory write occur.
- Write 0x20→0x555, then read 0x20 issued after the write pops → returns 0x555. The same read issued while the write is still queued → returns the old value.
